// File: rtl/fifo_pkg.sv
// Shared helpers for the dual-clock FIFO: pointer width derivation and
// binary/Gray conversions used on both sides of the clock crossing.
package fifo_pkg;

   // Widest pointer the conversion helpers handle; narrower pointers are
   // zero-extended in and truncated out by the caller.
   localparam int PTR_MAX_W = 32;

   typedef logic [PTR_MAX_W-1:0] ptr_word_t;

   // Ceiling log2 for deriving the address width from DEPTH.
   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < n) r = i + 1;
      end
      return r;
   endfunction

   // Binary to Gray; valid for any width up to PTR_MAX_W when zero-extended.
   function automatic ptr_word_t bin2gray(input ptr_word_t b);
      return b ^ (b >> 1);
   endfunction

   // Gray to binary; zero upper bits of a narrow pointer stay zero.
   function automatic ptr_word_t gray2bin(input ptr_word_t g);
      ptr_word_t b;
      b[PTR_MAX_W-1] = g[PTR_MAX_W-1];
      for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

endpackage

// File: rtl/gray_ptr_sync.sv
// Multi-flop synchroniser for a Gray-coded pointer; delivers the pointer in
// binary form in the destination clock domain.
module gray_ptr_sync
   import fifo_pkg::*;
#(
   parameter int W           = 5,
   parameter int SYNC_STAGES = 2
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [W-1:0] gray_in,
   output logic [W-1:0] bin_out
);

   logic [W-1:0] sync_q [SYNC_STAGES];

   // Shift the Gray pointer through the synchroniser chain.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      end else begin
         sync_q[0] <= gray_in;
         for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      end
   end

   assign bin_out = W'(gray2bin(ptr_word_t'(sync_q[SYNC_STAGES-1])));

endmodule

// File: rtl/async_fifo_gen2.sv
// Parametrised dual-clock FIFO with handshakes, registered read data,
// almost-full/almost-empty thresholds, per-domain levels and error pulses.
module async_fifo_gen2
   import fifo_pkg::*;
#(
   parameter  int WIDTH       = 8,
   parameter  int DEPTH       = 16,
   parameter  int AFULL_TH    = DEPTH - 4,
   parameter  int AEMPTY_TH   = 2,
   parameter  int SYNC_STAGES = 2,
   localparam int AW          = clog2(DEPTH)
) (
   input  logic             wr_clk,
   input  logic             reset,
   input  logic             rd_clk,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   output logic             wr_full,
   output logic             wr_afull,
   output logic [AW:0]      wr_level,
   output logic             wr_overflow,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             rd_valid,
   output logic             rd_empty,
   output logic             rd_aempty,
   output logic [AW:0]      rd_level,
   output logic             rd_underflow
);

   localparam int PW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];

   logic          wr_accept;
   logic [AW:0]   wptr, wptr_nxt, wptr_gray, rptr_sync, wr_level_nxt;
   logic          rd_accept;
   logic [AW:0]   rptr, rptr_nxt, rptr_gray, wptr_sync, rd_level_nxt;

   // Write-side next state: flags are computed from the post-write pointer so
   // a back-to-back write can never slip past a full condition.
   always_comb begin
      wr_accept    = wr_en & ~wr_full;
      wptr_nxt     = wptr + PW'(wr_accept);
      wr_level_nxt = wptr_nxt - rptr_sync;
   end

   // Write-domain pointer, Gray copy for the crossing, and status registers.
   always_ff @(posedge wr_clk or posedge reset) begin
      if (reset) begin
         wptr        <= '0;
         wptr_gray   <= '0;
         wr_level    <= '0;
         wr_full     <= 1'b0;
         wr_afull    <= 1'b0;
         wr_overflow <= 1'b0;
      end else begin
         wptr        <= wptr_nxt;
         wptr_gray   <= PW'(bin2gray(ptr_word_t'(wptr_nxt)));
         wr_level    <= wr_level_nxt;
         wr_full     <= (wr_level_nxt == PW'(DEPTH));
         wr_afull    <= (wr_level_nxt >= PW'(AFULL_TH));
         wr_overflow <= wr_en & wr_full;
      end
   end

   // Storage array: written only on accepted writes, never reset.
   always_ff @(posedge wr_clk) begin
      if (wr_accept) mem[wptr[AW-1:0]] <= wr_data;
   end

   // ---- write pointer into read domain / read pointer into write domain
   gray_ptr_sync #(.W(PW), .SYNC_STAGES(SYNC_STAGES)) u_wptr_to_rd (
      .clk     (rd_clk),
      .reset   (reset),
      .gray_in (wptr_gray),
      .bin_out (wptr_sync)
   );

   gray_ptr_sync #(.W(PW), .SYNC_STAGES(SYNC_STAGES)) u_rptr_to_wr (
      .clk     (wr_clk),
      .reset   (reset),
      .gray_in (rptr_gray),
      .bin_out (rptr_sync)
   );

   // Read-side next state, mirroring the write side.
   always_comb begin
      rd_accept    = rd_en & ~rd_empty;
      rptr_nxt     = rptr + PW'(rd_accept);
      rd_level_nxt = wptr_sync - rptr_nxt;
   end

   // Read-domain pointer, Gray copy for the crossing, and status registers.
   always_ff @(posedge rd_clk or posedge reset) begin
      if (reset) begin
         rptr         <= '0;
         rptr_gray    <= '0;
         rd_level     <= '0;
         rd_empty     <= 1'b1;
         rd_aempty    <= 1'b1;
         rd_valid     <= 1'b0;
         rd_underflow <= 1'b0;
      end else begin
         rptr         <= rptr_nxt;
         rptr_gray    <= PW'(bin2gray(ptr_word_t'(rptr_nxt)));
         rd_level     <= rd_level_nxt;
         rd_empty     <= (rd_level_nxt == '0);
         rd_aempty    <= (rd_level_nxt <= PW'(AEMPTY_TH));
         rd_valid     <= rd_accept;
         rd_underflow <= rd_en & rd_empty;
      end
   end

   // Registered read port; holds the last word when no read is accepted.
   always_ff @(posedge rd_clk or posedge reset) begin
      if (reset) begin
         rd_data <= '0;
      end else if (rd_accept) begin
         rd_data <= mem[rptr[AW-1:0]];
      end
   end

endmodule

// File: tb/tb_async_fifo_gen2.sv
// Self-checking bench for async_fifo_gen2: table-driven fill, hand-written
// corner sequences and a randomized stream checked against a queue model.
module tb_async_fifo_gen2;

   localparam int WIDTH     = 8;
   localparam int DEPTH     = 16;
   localparam int AFULL_TH  = 12;
   localparam int AEMPTY_TH = 2;
   localparam int SS        = 2;
   localparam int NWORDS    = 10000;

   logic             wr_clk = 1'b0;
   logic             rd_clk = 1'b0;
   logic             reset;
   logic             wr_en;
   logic [WIDTH-1:0] wr_data;
   logic             wr_full, wr_afull, wr_overflow;
   logic [4:0]       wr_level;
   logic             rd_en;
   logic [WIDTH-1:0] rd_data;
   logic             rd_valid, rd_empty, rd_aempty, rd_underflow;
   logic [4:0]       rd_level;

   always #5  wr_clk = ~wr_clk;
   always #14 rd_clk = ~rd_clk;

   async_fifo_gen2 #(
      .WIDTH(WIDTH), .DEPTH(DEPTH), .AFULL_TH(AFULL_TH),
      .AEMPTY_TH(AEMPTY_TH), .SYNC_STAGES(SS)
   ) dut (
      .wr_clk(wr_clk), .reset(reset), .rd_clk(rd_clk),
      .wr_en(wr_en), .wr_data(wr_data), .wr_full(wr_full),
      .wr_afull(wr_afull), .wr_level(wr_level), .wr_overflow(wr_overflow),
      .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid),
      .rd_empty(rd_empty), .rd_aempty(rd_aempty), .rd_level(rd_level),
      .rd_underflow(rd_underflow)
   );

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic       en;
      logic [7:0] d;
      logic [4:0] lvl;
      logic       full;
      logic       afull;
      logic       ovf;
   } fill_rec_t;

   fill_rec_t fill_tab[18];

   logic [WIDTH-1:0] q[$];
   bit rand_phase = 1'b0;
   int ovf_cnt = 0;
   int unf_cnt = 0;
   int vld_seen = 0;

   always @(posedge wr_clk) if (rand_phase && wr_overflow) ovf_cnt++;
   always @(posedge rd_clk) if (rand_phase && rd_underflow) unf_cnt++;

   initial begin
      int n;
      int lvl;

      // Expected fill behaviour from the occupancy rules: 17 writes, then idle.
      for (int i = 0; i < 17; i++) begin
         lvl = (i + 1 > DEPTH) ? DEPTH : i + 1;
         fill_tab[i].en    = 1'b1;
         fill_tab[i].d     = 8'(i);
         fill_tab[i].lvl   = 5'(lvl);
         fill_tab[i].full  = (lvl == DEPTH);
         fill_tab[i].afull = (lvl >= AFULL_TH);
         fill_tab[i].ovf   = (i == DEPTH);
      end
      fill_tab[17].en    = 1'b0;
      fill_tab[17].d     = 8'h00;
      fill_tab[17].lvl   = 5'(DEPTH);
      fill_tab[17].full  = 1'b1;
      fill_tab[17].afull = 1'b1;
      fill_tab[17].ovf   = 1'b0;

      reset   = 1'b1;
      wr_en   = 1'b0;
      rd_en   = 1'b0;
      wr_data = '0;
      repeat (3) @(posedge rd_clk);
      @(negedge wr_clk) reset = 1'b0;

      // Reset state and idle behaviour
      for (int i = 0; i < 8; i++) begin
         @(posedge rd_clk); #1;
         if (rd_valid) vld_seen++;
      end
      chk("idle_rd_valid", 32'(vld_seen), 0);
      chk("rst_rd_empty", 32'(rd_empty), 1);
      chk("rst_rd_aempty", 32'(rd_aempty), 1);
      chk("rst_rd_level", 32'(rd_level), 0);
      chk("rst_rd_data", 32'(rd_data), 0);
      chk("rst_rd_underflow", 32'(rd_underflow), 0);
      chk("rst_wr_full", 32'(wr_full), 0);
      chk("rst_wr_afull", 32'(wr_afull), 0);
      chk("rst_wr_level", 32'(wr_level), 0);
      chk("rst_wr_overflow", 32'(wr_overflow), 0);

      // Fill to full and beyond, table-driven
      for (int i = 0; i < 18; i++) begin
         @(negedge wr_clk);
         wr_en   = fill_tab[i].en;
         wr_data = fill_tab[i].d;
         @(posedge wr_clk); #1;
         chk($sformatf("fill%0d_level", i), 32'(wr_level), 32'(fill_tab[i].lvl));
         chk($sformatf("fill%0d_full", i), 32'(wr_full), 32'(fill_tab[i].full));
         chk($sformatf("fill%0d_afull", i), 32'(wr_afull), 32'(fill_tab[i].afull));
         chk($sformatf("fill%0d_ovf", i), 32'(wr_overflow), 32'(fill_tab[i].ovf));
      end
      @(negedge wr_clk) wr_en = 1'b0;

      repeat (6) @(posedge rd_clk); #1;
      chk("full_rd_level", 32'(rd_level), 16);
      chk("full_rd_empty", 32'(rd_empty), 0);
      chk("full_rd_aempty", 32'(rd_aempty), 0);

      // Drain: original 0x00..0x0F must come back, overflowed word absent
      @(negedge rd_clk) rd_en = 1'b1;
      for (int k = 0; k < DEPTH; k++) begin
         @(posedge rd_clk); #1;
         if (k == DEPTH - 1) rd_en = 1'b0;
         chk($sformatf("drain%0d_valid", k), 32'(rd_valid), 1);
         chk($sformatf("drain%0d_data", k), 32'(rd_data), 32'(k));
      end
      chk("drain_rd_empty", 32'(rd_empty), 1);
      chk("drain_rd_level", 32'(rd_level), 0);
      chk("drain_rd_aempty", 32'(rd_aempty), 1);
      @(posedge rd_clk); #1;
      chk("drain_valid_drop", 32'(rd_valid), 0);
      chk("drain_data_hold", 32'(rd_data), 32'h0F);

      repeat (6) @(posedge wr_clk); #1;
      chk("space_wr_level", 32'(wr_level), 0);
      chk("space_wr_full", 32'(wr_full), 0);
      chk("space_wr_afull", 32'(wr_afull), 0);

      // Read on empty: underflow pulse, no data, pointer untouched
      @(negedge rd_clk) rd_en = 1'b1;
      @(posedge rd_clk); #1;
      rd_en = 1'b0;
      chk("unf_pulse", 32'(rd_underflow), 1);
      chk("unf_valid", 32'(rd_valid), 0);
      @(posedge rd_clk); #1;
      chk("unf_pulse_end", 32'(rd_underflow), 0);

      @(negedge wr_clk);
      wr_en   = 1'b1;
      wr_data = 8'h3C;
      @(negedge wr_clk) wr_en = 1'b0;
      repeat (5) @(posedge rd_clk);
      @(negedge rd_clk) rd_en = 1'b1;
      @(posedge rd_clk); #1;
      rd_en = 1'b0;
      chk("after_unf_valid", 32'(rd_valid), 1);
      chk("after_unf_data", 32'(rd_data), 32'h3C);

      // Randomized stream against the queue model
      rand_phase = 1'b1;
      fork
         begin
            int sent;
            sent = 0;
            for (int c = 0; c < 60000 && sent < NWORDS; c++) begin
               @(negedge wr_clk);
               if (!wr_full && $urandom_range(0, 3) != 0) begin
                  wr_en   = 1'b1;
                  wr_data = 8'($urandom);
                  q.push_back(wr_data);
                  sent++;
               end else begin
                  wr_en = 1'b0;
               end
            end
            @(negedge wr_clk) wr_en = 1'b0;
            chk("rand_sent", 32'(sent), 32'(NWORDS));
         end
         begin
            int got;
            logic [WIDTH-1:0] exp_d;
            got = 0;
            for (int c = 0; c < 30000 && got < NWORDS; c++) begin
               @(negedge rd_clk);
               rd_en = !rd_empty && ($urandom_range(0, 7) != 0);
               @(posedge rd_clk); #1;
               if (rd_valid) begin
                  if (q.size() == 0) begin
                     chk("rand_extra_word", 1, 0);
                  end else begin
                     exp_d = q.pop_front();
                     chk("rand_data", 32'(rd_data), 32'(exp_d));
                  end
                  got++;
               end
            end
            rd_en = 1'b0;
            chk("rand_got", 32'(got), 32'(NWORDS));
         end
      join
      repeat (2) @(posedge rd_clk);
      rand_phase = 1'b0;
      chk("rand_no_overflow", 32'(ovf_cnt), 0);
      chk("rand_no_underflow", 32'(unf_cnt), 0);
      chk("rand_model_empty", 32'(q.size()), 0);

      // Reset with 9 words stored
      for (int i = 0; i < 9; i++) begin
         @(negedge wr_clk);
         wr_en   = 1'b1;
         wr_data = 8'(8'h50 + i);
      end
      @(negedge wr_clk) wr_en = 1'b0;
      repeat (6) @(posedge rd_clk); #1;
      chk("nine_rd_level", 32'(rd_level), 9);
      chk("nine_wr_level", 32'(wr_level), 9);

      @(posedge wr_clk); #3;
      reset = 1'b1;
      #1;
      chk("arst_wr_level", 32'(wr_level), 0);
      chk("arst_wr_afull", 32'(wr_afull), 0);
      chk("arst_rd_empty", 32'(rd_empty), 1);
      chk("arst_rd_aempty", 32'(rd_aempty), 1);
      chk("arst_rd_level", 32'(rd_level), 0);
      chk("arst_rd_data", 32'(rd_data), 0);
      repeat (3) @(posedge rd_clk);
      @(negedge wr_clk) reset = 1'b0;
      repeat (2) @(negedge wr_clk);
      wr_en   = 1'b1;
      wr_data = 8'hA5;
      @(posedge wr_clk); #1;
      wr_en = 1'b0;
      n = 9;
      for (int e = 1; e <= 8; e++) begin
         @(posedge rd_clk); #1;
         if (!rd_empty) begin
            n = e;
            break;
         end
      end
      chk("post_rst_latency_ok", 32'(n <= SS + 2), 1);
      @(negedge rd_clk) rd_en = 1'b1;
      @(posedge rd_clk); #1;
      rd_en = 1'b0;
      chk("post_rst_valid", 32'(rd_valid), 1);
      chk("post_rst_data", 32'(rd_data), 32'hA5);
      chk("post_rst_empty", 32'(rd_empty), 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
